// File: rtl/key_conditioner_pkg.sv
// Shared types and default timing constants for the push-button conditioning front end.
// Defaults assume a 50 MHz system clock.
package key_conditioner_pkg;

    localparam int unsigned DefDebounceCycles = 500_000;     // 10 ms
    localparam int unsigned DefLongCycles     = 50_000_000;  // 1 s

    typedef enum logic [1:0] {
        StRel,
        StPressChk,
        StHeld,
        StRelChk
    } key_state_e;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-FF synchronizer, debounce FSM, hold timer and registered
// press/release/long strobes.
module key_debounce_ch
    import key_conditioner_pkg::*;
#(
    parameter int unsigned DebounceCycles = DefDebounceCycles,
    parameter int unsigned LongCycles     = DefLongCycles
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_ni,
    output logic level_o,
    output logic pulse_o,
    output logic release_o,
    output logic long_o
);

    localparam int unsigned CntW  = $clog2(DebounceCycles);
    localparam int unsigned HoldW = $clog2(LongCycles) + 1;

    localparam logic [CntW-1:0]  CntOne   = CntW'(1);
    localparam logic [CntW-1:0]  CntLast  = CntW'(DebounceCycles - 1);
    localparam logic [HoldW-1:0] HoldOne  = HoldW'(1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(LongCycles - 1);
    localparam logic [HoldW-1:0] HoldMax  = HoldW'(LongCycles);

    logic [1:0]       sync_q;
    logic             s;
    key_state_e       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [HoldW-1:0] hold_q, hold_d, hold_inc;
    logic             pulse_q, pulse_d;
    logic             release_q, release_d;
    logic             long_q, long_d;
    logic             pressed;

    assign s        = sync_q[1];
    assign pressed  = (state_q == StHeld) || (state_q == StRelChk);
    // Saturate so the long strobe can fire at most once per press.
    assign hold_inc = (hold_q == HoldMax) ? hold_q : hold_q + HoldOne;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q    <= 2'b11;
            state_q   <= StRel;
            cnt_q     <= '0;
            hold_q    <= '0;
            pulse_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], key_ni};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            pulse_q   <= pulse_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        pulse_d   = 1'b0;
        release_d = 1'b0;
        long_d    = pressed && (hold_q == HoldLast);
        unique case (state_q)
            StRel: begin
                if (!s) begin
                    state_d = StPressChk;
                    cnt_d   = CntOne;
                end
            end
            StPressChk: begin
                if (s) begin
                    state_d = StRel;
                end else if (cnt_q == CntLast) begin
                    state_d = StHeld;
                    hold_d  = '0;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StHeld: begin
                hold_d = hold_inc;
                if (s) begin
                    state_d = StRelChk;
                    cnt_d   = CntOne;
                end
            end
            StRelChk: begin
                // Hold keeps counting through a release glitch.
                hold_d = hold_inc;
                if (!s) begin
                    state_d = StHeld;
                end else if (cnt_q == CntLast) begin
                    state_d   = StRel;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            default: state_d = StRel;
        endcase
    end

    assign level_o   = pressed;
    assign pulse_o   = pulse_q;
    assign release_o = release_q;
    assign long_o    = long_q;

endmodule

// File: rtl/key_conditioner.sv
// Conditions raw active-low board keys into debounced levels and single-cycle
// press, release and long-press strobes; one independent channel per key.
module key_conditioner
    import key_conditioner_pkg::*;
#(
    parameter int unsigned N_KEYS          = 3,
    parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
    parameter int unsigned LONG_CYCLES     = DefLongCycles
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [N_KEYS-1:0] i_key_n,
    output logic [N_KEYS-1:0] o_level,
    output logic [N_KEYS-1:0] o_pulse,
    output logic [N_KEYS-1:0] o_release,
    output logic [N_KEYS-1:0] o_long
);

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        key_debounce_ch #(
            .DebounceCycles(DEBOUNCE_CYCLES),
            .LongCycles    (LONG_CYCLES)
        ) u_ch (
            .clk_i    (i_clk),
            .rst_ni   (i_rst_n),
            .key_ni   (i_key_n[g]),
            .level_o  (o_level[g]),
            .pulse_o  (o_pulse[g]),
            .release_o(o_release[g]),
            .long_o   (o_long[g])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner: run-length / timestamp reference model
// compared every cycle, directed scenarios with literal latencies, then random keys.
module tb_key_conditioner;

    localparam int N = 3;
    localparam int D = 8;
    localparam int L = 40;

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic [N-1:0] i_key_n = '1;
    logic [N-1:0] o_level, o_pulse, o_release, o_long;

    key_conditioner #(
        .N_KEYS         (N),
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES    (L)
    ) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_key_n  (i_key_n),
        .o_level  (o_level),
        .o_pulse  (o_pulse),
        .o_release(o_release),
        .o_long   (o_long)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    // Inputs as seen by the DUT at the last rising edge.
    logic [N-1:0] key_s;
    logic         rst_s = 1'b0;
    always @(posedge i_clk) begin
        key_s <= i_key_n;
        rst_s <= i_rst_n;
    end

    // Reference model: two-sample delay line, run length of disagreeing samples,
    // and the cycle index of the latest accepted press.
    bit [N-1:0] s1_m, s2_m, lvl_m, exp_p, exp_r, exp_l;
    int         run_m   [N];
    int         press_t [N];
    int         mcyc;

    task automatic model_reset();
        s1_m  = '1;
        s2_m  = '1;
        lvl_m = '0;
        exp_p = '0;
        exp_r = '0;
        exp_l = '0;
        for (int k = 0; k < N; k++) begin
            run_m[k]   = 0;
            press_t[k] = -100000;
        end
    endtask

    task automatic model_step();
        bit s, was;
        for (int k = 0; k < N; k++) begin
            s        = s2_m[k];
            s2_m[k]  = s1_m[k];
            s1_m[k]  = key_s[k];
            was      = lvl_m[k];
            exp_p[k] = 1'b0;
            exp_r[k] = 1'b0;
            if ((!s) != lvl_m[k]) begin
                run_m[k]++;
                if (run_m[k] == D) begin
                    lvl_m[k] = !s;
                    run_m[k] = 0;
                    if (!s) begin
                        exp_p[k]   = 1'b1;
                        press_t[k] = mcyc;
                    end else begin
                        exp_r[k] = 1'b1;
                    end
                end
            end else begin
                run_m[k] = 0;
            end
            exp_l[k] = was && (mcyc - press_t[k] == L);
        end
        mcyc++;
    endtask

    // Observations of DUT strobes, used by the directed checks.
    int cyc_tb = 0;
    int pulse_cnt [N];
    int rel_cnt   [N];
    int long_cnt  [N];
    int pulse_t   [N];
    int rel_t     [N];
    int long_t    [N];

    initial begin
        mcyc = 0;
        model_reset();
        for (int k = 0; k < N; k++) begin
            pulse_cnt[k] = 0; rel_cnt[k] = 0; long_cnt[k] = 0;
            pulse_t[k] = 0;   rel_t[k] = 0;   long_t[k] = 0;
        end
        forever begin
            @(negedge i_clk);
            cyc_tb++;
            if (!i_rst_n || !rst_s) model_reset();
            else model_step();
            check("cycle_outputs", {20'd0, o_level, o_pulse, o_release, o_long},
                  {20'd0, lvl_m, exp_p, exp_r, exp_l});
            for (int k = 0; k < N; k++) begin
                if (o_pulse[k] === 1'b1) begin pulse_cnt[k]++; pulse_t[k] = cyc_tb; end
                if (o_release[k] === 1'b1) begin rel_cnt[k]++; rel_t[k] = cyc_tb; end
                if (o_long[k] === 1'b1) begin long_cnt[k]++; long_t[k] = cyc_tb; end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge i_clk);
        #1;
    endtask

    int t0;
    int dur [N];

    initial begin
        tick(3);
        check("reset_outputs", {20'd0, o_level, o_pulse, o_release, o_long}, 32'd0);
        i_rst_n = 1'b1;
        tick(100);
        check("idle_strobes", pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2]
              + rel_cnt[0] + long_cnt[0] + {29'd0, o_level}, 32'd0);

        // Clean press and release on key0.
        t0 = cyc_tb; i_key_n[0] = 1'b0;
        tick(20);
        check("k0_press_latency", pulse_t[0] - t0, 32'd10);
        check("k0_pulse_once", pulse_cnt[0], 32'd1);
        check("k0_level_high", {31'd0, o_level[0]}, 32'd1);
        t0 = cyc_tb; i_key_n[0] = 1'b1;
        tick(20);
        check("k0_release_latency", rel_t[0] - t0, 32'd10);
        check("k0_release_once", rel_cnt[0], 32'd1);
        check("k0_level_low", {31'd0, o_level[0]}, 32'd0);

        // Key1 bounces in 3-cycle segments, ending high, then settles low.
        for (int i = 0; i < 18; i++) begin
            i_key_n[1] = ((i / 3) % 2) != 0;
            tick(1);
        end
        check("k1_bounce_quiet", pulse_cnt[1], 32'd0);
        t0 = cyc_tb; i_key_n[1] = 1'b0;
        tick(20);
        check("k1_settle_latency", pulse_t[1] - t0, 32'd10);
        check("k1_single_pulse", pulse_cnt[1], 32'd1);
        i_key_n[1] = 1'b1;
        tick(20);

        // Key2 long hold, then a short release glitch after the long strobe.
        t0 = cyc_tb; i_key_n[2] = 1'b0;
        tick(55);
        check("k2_press_latency", pulse_t[2] - t0, 32'd10);
        check("k2_long_latency", long_t[2] - t0, 32'd50);
        check("k2_long_once", long_cnt[2], 32'd1);
        i_key_n[2] = 1'b1;
        tick(3);
        i_key_n[2] = 1'b0;
        tick(60);
        check("k2_glitch_no_long", long_cnt[2], 32'd1);
        check("k2_glitch_no_release", rel_cnt[2], 32'd0);
        i_key_n[2] = 1'b1;
        tick(20);
        check("k2_release_once", rel_cnt[2], 32'd1);

        // Simultaneous press on all keys.
        t0 = cyc_tb; i_key_n = '0;
        tick(15);
        for (int k = 0; k < N; k++) check($sformatf("all_press_k%0d", k), pulse_t[k] - t0, 32'd10);
        check("pre_reset_level", {29'd0, o_level}, 32'd7);

        // Reset pulse while keys are held; keys must re-qualify.
        i_rst_n = 1'b0;
        #1;
        check("reset_async_zero", {20'd0, o_level, o_pulse, o_release, o_long}, 32'd0);
        tick(1);
        i_rst_n = 1'b1; t0 = cyc_tb;
        tick(15);
        check("reset_repress_latency", pulse_t[0] - t0, 32'd10);
        i_key_n = '1;
        tick(20);

        // Randomised keys with a mix of glitches and long holds, rare resets.
        for (int k = 0; k < N; k++) dur[k] = 1;
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < N; k++) begin
                dur[k]--;
                if (dur[k] <= 0) begin
                    i_key_n[k] = ~i_key_n[k];
                    dur[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6))
                                                         : int'($urandom_range(8, 90));
                end
            end
            i_rst_n = ($urandom_range(0, 599) != 0);
            tick(1);
        end
        i_rst_n = 1'b1;
        tick(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
